// File: rtl/transcription_pkg.sv
// Shared constants and types for the note transcription path:
// buffer geometry, FSM states and the FFT-bin note boundaries.
package transcription_pkg;

  localparam int NUM_SLOTS       = 160;
  localparam int NOTE_W          = 6;
  localparam int BIN_W           = 12;
  localparam int STABLE_FRAMES   = 3;
  localparam int FRAMES_PER_SLOT = 4;
  localparam int NUM_NOTES       = 37;

  typedef logic [NOTE_W-1:0] note_t;

  typedef enum logic [1:0] {IDLE, CLEAR, REC, FULL} state_t;

  // Lower bin edge of each semitone C3..C6 (quarter-tone below the pitch).
  localparam logic [BIN_W-1:0] NOTE_BIN_LO [1:NUM_NOTES] = '{
    12'd43,  12'd46,  12'd49,  12'd51,  12'd54,  12'd58,  12'd61,  12'd65,
    12'd69,  12'd73,  12'd77,  12'd82,  12'd87,  12'd92,  12'd97,  12'd103,
    12'd109, 12'd116, 12'd123, 12'd130, 12'd138, 12'd146, 12'd155, 12'd164,
    12'd174, 12'd184, 12'd195, 12'd207, 12'd219, 12'd232, 12'd246, 12'd261,
    12'd276, 12'd293, 12'd310, 12'd329, 12'd348
  };

  localparam logic [BIN_W-1:0] NOTE_BIN_MAX = 12'd369;

endpackage

// File: rtl/bin_to_note.sv
// Registered lookup from an FFT peak bin to a note code (0 = rest),
// with the qualifying strobe delayed to stay aligned with the result.
module bin_to_note
  import transcription_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             peak_valid,
  input  logic [BIN_W-1:0] peak,
  output note_t            raw_note,
  output logic             raw_valid
);

  logic [NUM_NOTES:1] above;
  note_t              note_calc;

  generate
    for (genvar gi = 1; gi <= NUM_NOTES; gi++) begin : g_cmp
      assign above[gi] = (peak >= NOTE_BIN_LO[gi]);
    end
  endgenerate

  // Edges are ascending, so the highest matching index equals the match count.
  always_comb begin
    note_calc = '0;
    for (int k = 1; k <= NUM_NOTES; k++) begin
      note_calc = note_calc + NOTE_W'(above[k]);
    end
    if (peak >= NOTE_BIN_MAX) begin
      note_calc = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_note  <= '0;
      raw_valid <= 1'b0;
    end else begin
      raw_valid <= peak_valid;
      if (peak_valid) begin
        raw_note <= note_calc;
      end
    end
  end

endmodule

// File: rtl/transcription_controller.sv
// Record/clear/capture sequencer: debounces mapped notes across FFT frames
// and commits one held note per slot into the display note buffer.
module transcription_controller
  import transcription_pkg::*;
(
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        record_in,
  input  logic                        peak_valid_in,
  input  logic [BIN_W-1:0]            peak_in,
  output logic [NUM_SLOTS*NOTE_W-1:0] notes_out,
  output logic [7:0]                  wr_ptr_out,
  output note_t                       cur_note_out,
  output logic                        recording_out,
  output logic                        clearing_out,
  output logic                        full_out
);

  localparam int CNT_W = $clog2(STABLE_FRAMES + 1);
  localparam int FC_W  = $clog2(FRAMES_PER_SLOT);
  localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_FRAMES);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(FRAMES_PER_SLOT - 1);
  localparam logic [7:0]       LAST_SLOT = 8'(NUM_SLOTS - 1);

  state_t           state;
  logic             record_q;
  logic [7:0]       clr_ptr;
  logic [7:0]       wr_ptr;
  logic [FC_W-1:0]  frame_cnt;
  logic [CNT_W-1:0] cand_cnt;
  note_t            cand;
  note_t            cur_note;
  note_t            notes [NUM_SLOTS];

  note_t            raw_note;
  logic             raw_valid;
  logic             rec_edge;
  logic             commit;
  logic [CNT_W-1:0] cnt_next;
  note_t            held_next;

  bin_to_note u_bin_to_note (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .peak_valid (peak_valid_in),
    .peak       (peak_in),
    .raw_note   (raw_note),
    .raw_valid  (raw_valid)
  );

  assign rec_edge = record_in & ~record_q;
  assign commit   = raw_valid && (state == REC) && (frame_cnt == FC_LAST);

  // Candidate is compared against the incoming note before it is replaced.
  always_comb begin
    cnt_next = CNT_W'(1);
    if (raw_note == cand) begin
      cnt_next = (cand_cnt == STABLE_C) ? cand_cnt : cand_cnt + CNT_W'(1);
    end
    held_next = (cnt_next == STABLE_C) ? raw_note : cur_note;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      record_q      <= 1'b0;
      clr_ptr       <= '0;
      wr_ptr        <= '0;
      frame_cnt     <= '0;
      cand_cnt      <= '0;
      cand          <= '0;
      cur_note      <= '0;
      recording_out <= 1'b0;
      clearing_out  <= 1'b0;
      full_out      <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        notes[k] <= '0;
      end
    end else begin
      record_q <= record_in;
      case (state)
        IDLE: begin
          if (rec_edge) begin
            state        <= CLEAR;
            clr_ptr      <= '0;
            clearing_out <= 1'b1;
          end
        end
        CLEAR: begin
          notes[clr_ptr] <= '0;
          if (clr_ptr == LAST_SLOT) begin
            state         <= REC;
            clr_ptr       <= '0;
            wr_ptr        <= '0;
            frame_cnt     <= '0;
            cur_note      <= '0;
            clearing_out  <= 1'b0;
            recording_out <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 8'd1;
          end
        end
        REC: begin
          if (raw_valid) begin
            cand     <= raw_note;
            cand_cnt <= cnt_next;
            cur_note <= held_next;
            if (commit) begin
              notes[wr_ptr] <= held_next;
              wr_ptr        <= wr_ptr + 8'd1;
              frame_cnt     <= '0;
            end else begin
              frame_cnt <= frame_cnt + FC_W'(1);
            end
          end
          // A stop press wins over reaching the last slot.
          if (rec_edge) begin
            state         <= IDLE;
            recording_out <= 1'b0;
          end else if (commit && wr_ptr == LAST_SLOT) begin
            state         <= FULL;
            recording_out <= 1'b0;
            full_out      <= 1'b1;
          end
        end
        FULL: begin
          if (rec_edge) begin
            state        <= CLEAR;
            clr_ptr      <= '0;
            full_out     <= 1'b0;
            clearing_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_pack
      assign notes_out[gi*NOTE_W +: NOTE_W] = notes[gi];
    end
  endgenerate

  assign wr_ptr_out   = wr_ptr;
  assign cur_note_out = cur_note;

endmodule

// File: tb/tb_transcription_controller.sv
// Directed bench for transcription_controller: per-frame expectations are
// queued when a strobe is driven and checked when the update is due.
module tb_transcription_controller;
  import transcription_pkg::*;

  logic                        clk_in = 1'b0;
  logic                        rst_n_in;
  logic                        record_in;
  logic                        peak_valid_in;
  logic [BIN_W-1:0]            peak_in;
  logic [NUM_SLOTS*NOTE_W-1:0] notes_out;
  logic [7:0]                  wr_ptr_out;
  note_t                       cur_note_out;
  logic                        recording_out;
  logic                        clearing_out;
  logic                        full_out;

  transcription_controller dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .record_in     (record_in),
    .peak_valid_in (peak_valid_in),
    .peak_in       (peak_in),
    .notes_out     (notes_out),
    .wr_ptr_out    (wr_ptr_out),
    .cur_note_out  (cur_note_out),
    .recording_out (recording_out),
    .clearing_out  (clearing_out),
    .full_out      (full_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    note_t cur;
    bit    commit;
    int    slot;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    rec_mode = 0;
  int    exp_wr   = 0;
  int    exp_fc   = 0;
  note_t prev_cur = '0;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int count_ne(input note_t v);
    int n = 0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (notes_out[k*NOTE_W +: NOTE_W] !== v) n++;
    end
    return n;
  endfunction

  // One FFT frame; exp_cur is the held note expected after it when recording.
  task automatic frame(input logic [BIN_W-1:0] bin, input note_t exp_cur, input bit press = 1'b0);
    exp_t e;
    int   wr_before;
    wr_before = exp_wr;
    e.cur    = rec_mode ? exp_cur : prev_cur;
    e.commit = 1'b0;
    e.slot   = 0;
    if (rec_mode) begin
      if (exp_fc == FRAMES_PER_SLOT - 1) begin
        e.commit = 1'b1;
        e.slot   = exp_wr;
        exp_wr++;
        exp_fc   = 0;
      end else begin
        exp_fc++;
      end
    end
    exp_q.push_back(e);
    peak_in       = bin;
    peak_valid_in = 1'b1;
    tick;
    peak_valid_in = 1'b0;
    if (press) record_in = 1'b1;
    chk("latency_cur", cur_note_out, prev_cur);
    chk("latency_wr", wr_ptr_out, wr_before);
    tick;
    e = exp_q.pop_front();
    chk("cur_note", cur_note_out, e.cur);
    if (e.commit) begin
      chk("slot", notes_out[e.slot*NOTE_W +: NOTE_W], e.cur);
      chk("wr_ptr", wr_ptr_out, e.slot + 1);
    end
    prev_cur = e.cur;
    if (press || exp_wr == NUM_SLOTS) rec_mode = 1'b0;
    repeat (2) tick;
  endtask

  task automatic press_clear;
    int cnt = 0;
    record_in = 1'b1;
    tick;
    record_in = 1'b0;
    while (clearing_out && cnt < 1000) begin
      cnt++;
      tick;
    end
    chk("clear_cycles", cnt, NUM_SLOTS);
    chk("recording_after_clear", recording_out, 1);
    rec_mode = 1'b1;
    exp_wr   = 0;
    exp_fc   = 0;
    prev_cur = '0;
  endtask

  task automatic press_stop;
    record_in = 1'b1;
    tick;
    record_in = 1'b0;
    tick;
    chk("stopped", recording_out, 0);
    rec_mode = 1'b0;
  endtask

  initial begin
    rst_n_in      = 1'b0;
    record_in     = 1'b0;
    peak_valid_in = 1'b0;
    peak_in       = '0;
    repeat (3) tick;
    rst_n_in = 1'b1;
    tick;
    chk("rst_nonzero_slots", count_ne('0), 0);
    chk("rst_wr_ptr", wr_ptr_out, 0);
    chk("rst_cur", cur_note_out, 0);
    chk("rst_flags", {recording_out, clearing_out, full_out}, 0);

    // Frames while idle are ignored.
    for (int i = 0; i < 10; i++) frame(NOTE_BIN_LO[10], 6'd0);
    chk("idle_nonzero_slots", count_ne('0), 0);
    chk("idle_wr_ptr", wr_ptr_out, 0);
    chk("idle_flags", {recording_out, clearing_out, full_out}, 0);

    // Steady note.
    press_clear;
    for (int i = 0; i < 8; i++) frame(NOTE_BIN_LO[10], (i < 2) ? 6'd0 : 6'd10);
    chk("steady_wr_ptr", wr_ptr_out, 2);

    // Debounce with a glitch.
    press_stop;
    press_clear;
    frame(NOTE_BIN_LO[5], 6'd0);
    frame(NOTE_BIN_LO[5], 6'd0);
    frame(NOTE_BIN_LO[7], 6'd0);
    frame(NOTE_BIN_LO[5], 6'd0);
    frame(NOTE_BIN_LO[5], 6'd0);
    frame(NOTE_BIN_LO[5], 6'd5);
    frame(NOTE_BIN_LO[5], 6'd5);
    frame(NOTE_BIN_LO[5], 6'd5);
    chk("dbc_slot0", notes_out[0 +: NOTE_W], 0);

    // Out-of-range bins below and above the table.
    for (int i = 0; i < 4; i++) frame(NOTE_BIN_LO[12], (i < 2) ? 6'd5 : 6'd12);
    for (int i = 0; i < 4; i++) frame(12'd0, (i < 2) ? 6'd12 : 6'd0);
    for (int i = 0; i < 4; i++) frame(NOTE_BIN_LO[12], (i < 2) ? 6'd0 : 6'd12);
    for (int i = 0; i < 4; i++) frame(NOTE_BIN_MAX, (i < 2) ? 6'd12 : 6'd0);
    chk("oor_slot3", notes_out[3*NOTE_W +: NOTE_W], 0);
    chk("oor_slot5", notes_out[5*NOTE_W +: NOTE_W], 0);

    // Fill the whole buffer, then confirm it is frozen.
    press_stop;
    press_clear;
    for (int i = 0; i < NUM_SLOTS * FRAMES_PER_SLOT; i++) begin
      frame(NOTE_BIN_LO[1], (i < 2) ? 6'd0 : 6'd1);
    end
    chk("fill_full", full_out, 1);
    chk("fill_recording", recording_out, 0);
    chk("fill_wr_ptr", wr_ptr_out, NUM_SLOTS);
    chk("fill_slots_not_1", count_ne(6'd1), 0);
    for (int i = 0; i < 8; i++) frame(NOTE_BIN_LO[20], 6'd1);
    chk("frozen_slots_not_1", count_ne(6'd1), 0);
    chk("frozen_wr_ptr", wr_ptr_out, NUM_SLOTS);
    chk("frozen_full", full_out, 1);
    press_clear;
    chk("reclear_nonzero_slots", count_ne('0), 0);
    chk("reclear_full", full_out, 0);
    chk("reclear_wr_ptr", wr_ptr_out, 0);

    // Stop press on the same edge as the slot-3 commit.
    for (int i = 0; i < 16; i++) begin
      frame(NOTE_BIN_LO[20], (i < 2) ? 6'd0 : 6'd20, (i == 15));
    end
    record_in = 1'b0;
    tick;
    chk("coll_recording", recording_out, 0);
    chk("coll_full", full_out, 0);
    chk("coll_wr_ptr", wr_ptr_out, 4);
    chk("coll_slot3", notes_out[3*NOTE_W +: NOTE_W], 20);

    // Asynchronous reset in the middle of a clear.
    record_in = 1'b1;
    tick;
    record_in = 1'b0;
    repeat (50) tick;
    chk("midclear_clearing", clearing_out, 1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("arst_clearing", clearing_out, 0);
    chk("arst_wr_ptr", wr_ptr_out, 0);
    chk("arst_cur", cur_note_out, 0);
    chk("arst_flags", {recording_out, full_out}, 0);
    chk("arst_nonzero_slots", count_ne('0), 0);
    tick;
    rst_n_in = 1'b1;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
